// File: rtl/bird_motion_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : bird_motion_ctrl_if
//  Description : Bundle between the scene/collision side and the bird motion
//                controller.
//                master : drives frame_tick, state_number, flap_button, collide
//                         and observes bird_y, bird_vel, dead, flap_event.
//                slave  : the motion controller itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bird_motion_ctrl_if #(
  parameter int Y_WIDTH = 10
);
  logic                    frame_tick;    // one-cycle pulse per frame
  logic [1:0]              state_number;  // 00 start, 01 gameplay, 10 gameover
  logic                    flap_button;   // raw, active-low, asynchronous
  logic                    collide;       // pipe overlap, valid on frame_tick
  logic [Y_WIDTH-1:0]      bird_y;        // bird top row
  logic signed [7:0]       bird_vel;      // signed velocity, px/frame
  logic                    dead;          // high in FALL and DEAD
  logic                    flap_event;    // one-cycle pulse per accepted flap

  modport master (
    output frame_tick, state_number, flap_button, collide,
    input  bird_y, bird_vel, dead, flap_event
  );

  modport slave (
    input  frame_tick, state_number, flap_button, collide,
    output bird_y, bird_vel, dead, flap_event
  );
endinterface
`default_nettype wire

// File: rtl/bird_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bird_motion_ctrl
//  Description : Per-frame vertical motion controller for the bird. Integrates
//                velocity and position once per frame, handles flaps, ceiling
//                and floor clamps, and reports death to the scene FSM.
//  Ports       : clk  - system clock
//                rst  - synchronous, active-low reset
//                bus  - bird_motion_ctrl_if.slave (frame_tick, state_number,
//                       flap_button, collide in; bird_y, bird_vel, dead,
//                       flap_event out)
//  Options     : BIRD_HOVER_EN - when defined, the bird bobs +/-4 px in IDLE
//                and READY (1 px every 4 ticks). Undefined: parked at START_Y.
//  Revision    : 1.0 - initial release
// ============================================================================
module bird_motion_ctrl #(
  parameter int Y_WIDTH  = 10,
  parameter int START_Y  = 240,
  parameter int FLOOR_Y  = 456,
  parameter int BIRD_H   = 24,
  parameter int GRAVITY  = 1,
  parameter int FLAP_VEL = -8,
  parameter int MAX_FALL = 10
) (
  input  logic               clk,
  input  logic               rst,
  bird_motion_ctrl_if.slave  bus
);

  localparam int AW = Y_WIDTH + 2;

  localparam logic signed [AW-1:0]  c_floor_top = AW'(FLOOR_Y - BIRD_H);
  localparam logic signed [AW-1:0]  c_max_fall  = AW'(MAX_FALL);
  localparam logic signed [AW-1:0]  c_flap_vel  = AW'(FLAP_VEL);
  localparam logic signed [AW-1:0]  c_gravity   = AW'(GRAVITY);
  localparam logic [Y_WIDTH-1:0]    c_start_y   = Y_WIDTH'(START_Y);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_FLY   = 3'd2,
    S_FALL  = 3'd3,
    S_DEAD  = 3'd4
  } state_t;

  state_t              r_state, w_state_n;
  logic [Y_WIDTH-1:0]  r_y, w_y_n;
  logic signed [7:0]   r_vel, w_vel_n;
  logic                r_pending, w_pending_n;
  logic                r_flap_event, w_flap_event_n;

  // Button synchronizer and edge register; all idle high (released).
  logic r_sync1, r_sync2, r_btn_d;
  logic r_tick_d;
  logic w_flap_edge, w_tick;

  assign w_flap_edge = r_btn_d & ~r_sync2;
  // A tick held high for several cycles counts once.
  assign w_tick      = bus.frame_tick & ~r_tick_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_btn_d  <= 1'b1;
      r_tick_d <= 1'b0;
    end else begin
      r_sync1  <= bus.flap_button;
      r_sync2  <= r_sync1;
      r_btn_d  <= r_sync2;
      r_tick_d <= bus.frame_tick;
    end
  end

  // Parked position in IDLE/READY.
  logic [Y_WIDTH-1:0] w_hover_y;

`ifdef BIRD_HOVER_EN
  logic [1:0]        r_hov_div;
  logic signed [3:0] r_hov_off;
  logic              r_hov_up;

  always_ff @(posedge clk) begin
    if (!rst || bus.state_number == 2'b00) begin
      r_hov_div <= 2'd0;
      r_hov_off <= 4'sd0;
      r_hov_up  <= 1'b1;
    end else if (w_tick && (r_state == S_IDLE || r_state == S_READY)) begin
      r_hov_div <= r_hov_div + 2'd1;
      if (r_hov_div == 2'd3) begin
        if (r_hov_up) begin
          r_hov_off <= r_hov_off + 4'sd1;
          if (r_hov_off == 4'sd3) r_hov_up <= 1'b0;
        end else begin
          r_hov_off <= r_hov_off - 4'sd1;
          if (r_hov_off == -4'sd3) r_hov_up <= 1'b1;
        end
      end
    end
  end

  assign w_hover_y = Y_WIDTH'(START_Y + int'(r_hov_off));
`else
  assign w_hover_y = c_start_y;
`endif

  // Datapath: all arithmetic in AW signed bits so the ceiling test sees
  // negative results before truncation.
  logic signed [AW-1:0] w_vel_ext, w_vel_inc, w_grav_vel, w_fly_vel;
  logic signed [AW-1:0] w_y_ext, w_fly_y, w_fall_y;
  logic                 w_pending_eff;

  assign w_pending_eff = r_pending | w_flap_edge;
  assign w_vel_ext     = AW'(r_vel);
  assign w_y_ext       = signed'({2'b00, r_y});
  assign w_vel_inc     = w_vel_ext + c_gravity;
  assign w_grav_vel    = (w_vel_inc > c_max_fall) ? c_max_fall : w_vel_inc;
  assign w_fly_vel     = w_pending_eff ? c_flap_vel : w_grav_vel;
  assign w_fly_y       = w_y_ext + w_fly_vel;
  assign w_fall_y      = w_y_ext + w_grav_vel;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_y          <= c_start_y;
      r_vel        <= 8'sd0;
      r_pending    <= 1'b0;
      r_flap_event <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_y          <= w_y_n;
      r_vel        <= w_vel_n;
      r_pending    <= w_pending_n;
      r_flap_event <= w_flap_event_n;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_y_n          = r_y;
    w_vel_n        = r_vel;
    w_pending_n    = r_pending;
    w_flap_event_n = 1'b0;

    if (bus.state_number == 2'b00) begin
      w_state_n   = S_IDLE;
      w_y_n       = c_start_y;
      w_vel_n     = 8'sd0;
      w_pending_n = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_y_n       = w_hover_y;
          w_vel_n     = 8'sd0;
          w_pending_n = 1'b0;
          if (bus.state_number == 2'b01) w_state_n = S_READY;
        end

        S_READY: begin
          w_y_n   = w_hover_y;
          w_vel_n = 8'sd0;
          // First flap only arms the bird; it is applied on the next tick.
          if (w_flap_edge) begin
            w_state_n      = S_FLY;
            w_pending_n    = 1'b1;
            w_flap_event_n = 1'b1;
          end
        end

        S_FLY: begin
          if (w_flap_edge) w_flap_event_n = 1'b1;
          if (w_tick) begin
            w_pending_n = 1'b0;
            if (w_fly_y < 0) begin
              w_y_n   = '0;
              w_vel_n = 8'sd0;
            end else if (w_fly_y >= c_floor_top) begin
              w_y_n     = c_floor_top[Y_WIDTH-1:0];
              w_vel_n   = 8'sd0;
              w_state_n = S_DEAD;
            end else begin
              w_y_n   = w_fly_y[Y_WIDTH-1:0];
              w_vel_n = w_fly_vel[7:0];
              if (bus.collide) w_state_n = S_FALL;
            end
          end else if (w_flap_edge) begin
            w_pending_n = 1'b1;
          end
        end

        S_FALL: begin
          w_pending_n = 1'b0;
          if (w_tick) begin
            if (w_fall_y < 0) begin
              w_y_n   = '0;
              w_vel_n = 8'sd0;
            end else if (w_fall_y >= c_floor_top) begin
              w_y_n     = c_floor_top[Y_WIDTH-1:0];
              w_vel_n   = 8'sd0;
              w_state_n = S_DEAD;
            end else begin
              w_y_n   = w_fall_y[Y_WIDTH-1:0];
              w_vel_n = w_grav_vel[7:0];
            end
          end
        end

        S_DEAD: begin
          w_pending_n = 1'b0;
        end

        default: begin
          w_state_n = S_IDLE;
        end
      endcase
    end
  end

  assign bus.bird_y     = r_y;
  assign bus.bird_vel   = r_vel;
  assign bus.dead       = (r_state == S_FALL) || (r_state == S_DEAD);
  assign bus.flap_event = r_flap_event;

endmodule
`default_nettype wire

// File: tb/tb_bird_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bird_motion_ctrl
//  Description : Randomized self-checking bench for bird_motion_ctrl. A
//                reference model of the game rules pushes the expected outputs
//                for every clock into a queue; a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bird_motion_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bird_motion_ctrl_if #(.Y_WIDTH(10)) bus ();

  bird_motion_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int y;
    int vel;
    bit dead;
    bit fe;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_READY = 1, M_FLY = 2, M_FALL = 3, M_DEAD = 4;
  localparam int FLOOR_TOP = 456 - 24;

  int m_st, m_y, m_vel;
  bit m_pend, m_fe, m_tprev;
  bit pm1, pm2, pm3;   // button pin as sampled at the last three edges

  function automatic int fall_vel(int v);
    return (v + 1 > 10) ? 10 : v + 1;
  endfunction

  // Advance the model across one clock edge using the inputs held before it.
  task automatic model_step();
    bit fedge, tk, fe_n, applied;
    int v, ny;
    fedge = !pm2 && pm3;
    if (!rst) begin
      m_st = M_IDLE; m_y = 240; m_vel = 0; m_pend = 0; m_fe = 0; m_tprev = 0;
      pm1 = 1; pm2 = 1; pm3 = 1;
    end else begin
      pm3 = pm2; pm2 = pm1; pm1 = bus.flap_button;
      tk = bus.frame_tick && !m_tprev;
      m_tprev = bus.frame_tick;
      fe_n = 0;
      applied = 0;
      if (bus.state_number == 2'b00) begin
        m_st = M_IDLE; m_y = 240; m_vel = 0; m_pend = 0;
      end else begin
        case (m_st)
          M_IDLE: begin
            m_y = 240; m_vel = 0; m_pend = 0;
            if (bus.state_number == 2'b01) m_st = M_READY;
          end
          M_READY: if (fedge) begin m_st = M_FLY; m_pend = 1; fe_n = 1; end
          M_FLY: begin
            fe_n = fedge;
            if (tk) begin
              v  = (m_pend || fedge) ? -8 : fall_vel(m_vel);
              ny = m_y + v;
              m_pend = 0;
              applied = 1;
            end else if (fedge) m_pend = 1;
          end
          M_FALL: begin
            m_pend = 0;
            if (tk) begin v = fall_vel(m_vel); ny = m_y + v; applied = 1; end
          end
          default: m_pend = 0;
        endcase
        if (applied) begin
          if (ny < 0) begin m_y = 0; m_vel = 0; end
          else if (ny >= FLOOR_TOP) begin m_y = FLOOR_TOP; m_vel = 0; m_st = M_DEAD; end
          else begin
            m_y = ny; m_vel = v;
            if (m_st == M_FLY && bus.collide) m_st = M_FALL;
          end
        end
      end
      m_fe = fe_n;
    end
    q.push_back('{m_y, m_vel, (m_st == M_FALL || m_st == M_DEAD), m_fe});
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    mon_en = 1'b1;
    #1;
  endtask

  // ---------------- monitor ----------------
  task automatic check(string name, int act, int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: actual %0d required %0d", name, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL queue_empty at %0t: actual 0 entries required 1", $time);
        end else begin
          e = q.pop_front();
          check("bird_y",     int'(bus.bird_y),            e.y);
          check("bird_vel",   int'($signed(bus.bird_vel)), e.vel);
          check("dead",       int'(bus.dead),              int'(e.dead));
          check("flap_event", int'(bus.flap_event),        int'(e.fe));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int frame_cnt, tick_hold, press_left, cool, rate, crate, kind;
  bit first_press;

  task automatic drive_cycle();
    if (tick_hold > 0) begin
      bus.frame_tick = 1'b1; tick_hold--;
    end else if (frame_cnt == 0) begin
      bus.frame_tick = 1'b1;
      tick_hold = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      frame_cnt = $urandom_range(3, 6);
    end else begin
      bus.frame_tick = 1'b0; frame_cnt--;
    end
    if (press_left > 0) begin
      bus.flap_button = 1'b0; press_left--;
      if (press_left == 0) cool = 2;
    end else begin
      bus.flap_button = 1'b1;
      if (cool > 0) cool--;
      else if (first_press || $urandom_range(0, 99) < rate) begin
        first_press = 0;
        press_left = $urandom_range(2, 4);
      end
    end
    bus.collide = ($urandom_range(0, 99) < crate);
  endtask

  initial begin
    rst = 1'b0;
    bus.frame_tick = 1'b0; bus.state_number = 2'b00;
    bus.flap_button = 1'b1; bus.collide = 1'b0;
    frame_cnt = 2; tick_hold = 0; press_left = 0; cool = 0;
    first_press = 0; rate = 0; crate = 0;
    repeat (2) step();
    rst = 1'b1;

    for (int ep = 0; ep < 40; ep++) begin
      kind = (ep < 4) ? ep : int'($urandom_range(0, 3));
      case (kind)
        0: begin rate = 0;  crate = 0;  end  // single flap, free fall to floor
        1: begin rate = 40; crate = 0;  end  // rapid flaps, ceiling clamp
        2: begin rate = 6;  crate = 4;  end  // collisions with flaps in flight
        default: begin rate = 10; crate = 2; end
      endcase
      bus.state_number = 2'b00;
      repeat (3) begin drive_cycle(); step(); end
      bus.state_number = 2'b01;
      repeat (25) begin bus.flap_button = 1'b1; bus.frame_tick = 1'b0; step(); end
      press_left = 0; cool = 0; first_press = 1;
      for (int c = 0; c < 300; c++) begin
        drive_cycle();
        if (kind == 3 && c == 150) bus.state_number = 2'b10;
        if (kind == 3 && c == 250) bus.state_number = 2'b00;
        if (kind == 3 && c == 253) bus.state_number = 2'b01;
        rst = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
        step();
      end
      rst = 1'b1;
    end

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
